// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared decode-pipeline types and constants
package pipeline_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hazard_state_t;

  localparam int REG_PC = 15;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-write scoreboard with rs1/rs2/rd lookup
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int PCREG        = REG_PC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    setEnable,
  input  logic [ADDRESSWIDTH-1:0] setAddress,
  input  logic                    clearEnable,
  input  logic [ADDRESSWIDTH-1:0] clearAddress,
  input  logic [ADDRESSWIDTH-1:0] rs1,
  input  logic [ADDRESSWIDTH-1:0] rs2,
  input  logic [ADDRESSWIDTH-1:0] rd,
  output logic                    pendingRs1,
  output logic                    pendingRs2,
  output logic                    pendingRd
);

  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = ADDRESSWIDTH'(PCREG);

  logic [REGNUM-1:0] pending;

  // Set is applied after clear so a younger writer keeps the register busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (clearEnable && clearAddress != PC_ADDR)
        pending[clearAddress] <= 1'b0;
      if (setEnable && setAddress != PC_ADDR)
        pending[setAddress] <= 1'b1;
    end
  end

  // The PC is read from its own path, so it never reports busy.
  assign pendingRs1 = pending[rs1] & (rs1 != PC_ADDR);
  assign pendingRs2 = pending[rs2] & (rs2 != PC_ADDR);
  assign pendingRd  = pending[rd]  & (rd  != PC_ADDR);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - decode interlock and branch flush sequencer
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int PCREG        = REG_PC,
  parameter int FLUSHCYCLES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    decodeValid,
  input  logic [ADDRESSWIDTH-1:0] rs1,
  input  logic [ADDRESSWIDTH-1:0] rs2,
  input  logic [ADDRESSWIDTH-1:0] rd,
  input  logic                    usesRs1,
  input  logic                    usesRs2,
  input  logic                    writesRd,
  input  logic                    wbEnable,
  input  logic [ADDRESSWIDTH-1:0] wbAddress,
  input  logic                    branchTaken,
  output logic                    stallFetch,
  output logic                    stallDecode,
  output logic                    flushDecode,
  output logic                    flushExecute,
  output logic                    issue
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]             stallCycles
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSHCYCLES);

  hazard_state_t state, state_next;
  logic [2:0]    flush_cnt, flush_cnt_next;
  logic          pend_rs1, pend_rs2, pend_rd;
  logic          hazard;

  hazard_scoreboard #(
    .REGNUM       (REGNUM),
    .ADDRESSWIDTH (ADDRESSWIDTH),
    .PCREG        (PCREG)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .setEnable    (issue & writesRd),
    .setAddress   (rd),
    .clearEnable  (wbEnable),
    .clearAddress (wbAddress),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .pendingRs1   (pend_rs1),
    .pendingRs2   (pend_rs2),
    .pendingRd    (pend_rd)
  );

  assign hazard = decodeValid &
                  ((usesRs1 & pend_rs1) | (usesRs2 & pend_rs2) | (writesRd & pend_rd));

  always_comb begin
    stallFetch     = 1'b0;
    stallDecode    = 1'b0;
    flushDecode    = 1'b0;
    flushExecute   = 1'b0;
    issue          = 1'b0;
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      HZ_FLUSH: begin
        flushDecode  = 1'b1;
        flushExecute = 1'b1;
        if (flush_cnt <= 3'd1) begin
          state_next     = HZ_RUN;
          flush_cnt_next = 3'd0;
        end else begin
          flush_cnt_next = flush_cnt - 3'd1;
        end
      end
      // RUN and STALL share outputs; STALL releases and issues in the same cycle.
      default: begin
        stallFetch   = hazard;
        stallDecode  = hazard;
        flushExecute = hazard;
        issue        = decodeValid & ~hazard;
        state_next   = hazard ? HZ_STALL : HZ_RUN;
      end
    endcase
    if (branchTaken) begin
      state_next     = HZ_FLUSH;
      flush_cnt_next = FLUSH_INIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HZ_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock) begin
    if (reset)
      stallCycles <= 16'd0;
    else if (stallDecode && stallCycles != 16'hFFFF)
      stallCycles <= stallCycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;
  import pipeline_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       decodeValid;
  logic [3:0] rs1, rs2, rd;
  logic       usesRs1, usesRs2, writesRd;
  logic       wbEnable;
  logic [3:0] wbAddress;
  logic       branchTaken;
  logic       stallFetch, stallDecode, flushDecode, flushExecute, issue;
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCycles;
`endif

  int total  = 0;
  int passed = 0;

  hazard_controller dut (
    .clock        (clock),
    .reset        (reset),
    .decodeValid  (decodeValid),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .usesRs1      (usesRs1),
    .usesRs2      (usesRs2),
    .writesRd     (writesRd),
    .wbEnable     (wbEnable),
    .wbAddress    (wbAddress),
    .branchTaken  (branchTaken),
    .stallFetch   (stallFetch),
    .stallDecode  (stallDecode),
    .flushDecode  (flushDecode),
    .flushExecute (flushExecute),
    .issue        (issue)
`ifdef HAZARD_STATS_EN
    ,
    .stallCycles  (stallCycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // {stallFetch, stallDecode, flushDecode, flushExecute, issue}
  function automatic logic [31:0] outs();
    return {27'd0, stallFetch, stallDecode, flushDecode, flushExecute, issue};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic dec(input logic v, input logic [3:0] a1, input logic u1,
                     input logic [3:0] a2, input logic u2,
                     input logic [3:0] d, input logic w);
    decodeValid = v; rs1 = a1; usesRs1 = u1; rs2 = a2; usesRs2 = u2; rd = d; writesRd = w;
    #1;
  endtask

  initial begin
    reset = 1'b1; branchTaken = 1'b0; wbEnable = 1'b0; wbAddress = 4'd0;
    dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc(); cyc();
    reset = 1'b0;
    dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check("reset_outs", outs(), 32'h00);
    check("reset_pending", 32'(dut.u_scoreboard.pending), 32'h0000);
    check("reset_state", 32'(dut.state), 32'(HZ_RUN));

    // RAW on r3 with writeback, no same-cycle bypass
    dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1);
    check("t2_issue_rd3", outs(), 32'h01);
    cyc();
    dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1);
    check("t2_raw_stall", outs(), 32'h1A);
    cyc();
    wbEnable = 1'b1; wbAddress = 4'd3; #1;
    check("t2_no_bypass", outs(), 32'h1A);
    check("t2_state_stall", 32'(dut.state), 32'(HZ_STALL));
    cyc();
    wbEnable = 1'b0; #1;
    check("t2_release_issue", outs(), 32'h01);
    cyc();
    dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check("t2_pending", 32'(dut.u_scoreboard.pending), 32'h0010);

    // same-cycle set and clear on r5: set wins
    dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
    wbEnable = 1'b1; wbAddress = 4'd5; #1;
    check("t3_issue", outs(), 32'h01);
    cyc();
    wbEnable = 1'b0;
    check("t3_pending_set_wins", 32'(dut.u_scoreboard.pending), 32'h0030);

    // PC alias never stalls or becomes pending
    dec(1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1);
    check("t5_pc_issue1", outs(), 32'h01);
    cyc();
    check("t5_pc_issue2", outs(), 32'h01);
    check("t5_pending", 32'(dut.u_scoreboard.pending), 32'h0030);
    cyc();

    // branch during STALL -> two flush cycles, then RUN
    dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    check("t4_stall", outs(), 32'h1A);
    cyc();
    branchTaken = 1'b1; #1;
    check("t4_branch_cycle", outs(), 32'h1A);
    cyc();
    branchTaken = 1'b0; #1;
    check("t4_flush1", outs(), 32'h06);
    cyc();
    check("t4_flush2", outs(), 32'h06);
    cyc();
    check("t4_back_run", outs(), 32'h1A);
    check("t4_state_run", 32'(dut.state), 32'(HZ_STALL) ^ 32'(HZ_STALL) ^ 32'(HZ_RUN));
    cyc();

    // reset held two cycles while stalled
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check("t1_outs", outs(), 32'h00);
    check("t1_state", 32'(dut.state), 32'(HZ_RUN));
    check("t1_pending", 32'(dut.u_scoreboard.pending), 32'h0000);
    dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    check("t1_no_stale_hazard", outs(), 32'h01);

`ifdef HAZARD_STATS_EN
    check("t6_stats_reset", 32'(stallCycles), 32'd0);
    dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1);
    cyc();
    dec(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (5) cyc();
    dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check("t6_stats_five", 32'(stallCycles), 32'd5);
    dec(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (65540) cyc();
    check("t6_stats_saturate", 32'(stallCycles), 32'h0000FFFF);
    dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
